// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller.
// State encodings live here so the top and any debug logic agree on them.
package ex_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_FLUSH = 2'd1,
    HZ_MEMW  = 2'd2
  } hz_state_e;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned FL_CNT_W  = 3;

endpackage

// File: rtl/hz_loaduse_det.sv
// Load-use comparator: flags a decode instruction that reads the register
// a load in execute has not yet produced. Purely combinational.
module hz_loaduse_det
  import ex_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic                 use_rs1,
  input  logic                 use_rs2,
  input  logic [REG_IDX_W-1:0] wreg,
  input  logic                 is_load,
  output logic                 hit
);

  logic match_rs1;
  logic match_rs2;

  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign match_rs1 = use_rs1 && (rs1 == wreg);
  assign match_rs2 = use_rs2 && (rs2 == wreg);
  assign hit       = is_load && (wreg != '0) && (match_rs1 || match_rs2);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and memory
// freezes for the IF/ID, ID/EX and EX/MEM registers, plus debug counters.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_LEN = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_wreg,
  input  logic                 ex_is_load,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_keep,
  output logic                 ifid_keep,
  output logic                 ifid_nop,
  output logic                 idex_keep,
  output logic                 idex_nop,
  output logic                 exmem_keep,
  output logic                 busy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [FL_CNT_W-1:0] FL_INIT = FL_CNT_W'(FLUSH_LEN - 1);

  hz_state_e            state_q, state_d, eff_state;
  logic [FL_CNT_W-1:0]  fl_cnt_q, fl_cnt_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic                 lu, mw, freeze, flush, lu_stall, flush_evt;

  hz_loaduse_det u_lu (
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .use_rs1 (id_use_rs1),
    .use_rs2 (id_use_rs2),
    .wreg    (ex_wreg),
    .is_load (ex_is_load),
    .hit     (lu)
  );

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    mw = mem_req && !mem_ready;

    // The cycle MEM_WAIT sees mem_ready behaves like the state it resumes,
    // so a re-presented branch or a pending flush cycle is acted on at once.
    eff_state = state_q;
    if (state_q == HZ_MEMW && mem_ready) begin
      eff_state = (fl_cnt_q != '0) ? HZ_FLUSH : HZ_RUN;
    end

    freeze   = mw || (state_q == HZ_MEMW && !mem_ready);
    flush    = !freeze && ((eff_state == HZ_RUN && ex_branch_taken) ||
                           eff_state == HZ_FLUSH);
    lu_stall = !freeze && !flush && eff_state == HZ_RUN && lu;

    pc_keep    = !rst && (freeze || lu_stall);
    ifid_keep  = !rst && (freeze || lu_stall);
    idex_keep  = !rst && freeze;
    exmem_keep = !rst && freeze;
    ifid_nop   = !rst && flush;
    idex_nop   = !rst && (flush || lu_stall);
    busy       = !rst && (state_q != HZ_RUN);

    state_d   = eff_state;
    fl_cnt_d  = fl_cnt_q;
    flush_evt = 1'b0;
    unique case (eff_state)
      HZ_RUN: begin
        if (mw) begin
          state_d = HZ_MEMW;
        end else if (ex_branch_taken) begin
          flush_evt = 1'b1;
          if (FLUSH_LEN > 1) begin
            state_d  = HZ_FLUSH;
            fl_cnt_d = FL_INIT;
          end
        end
      end
      HZ_FLUSH: begin
        if (mw) begin
          state_d = HZ_MEMW;
        end else if (fl_cnt_q <= FL_CNT_W'(1)) begin
          state_d  = HZ_RUN;
          fl_cnt_d = '0;
        end else begin
          fl_cnt_d = fl_cnt_q - FL_CNT_W'(1);
        end
      end
      HZ_MEMW: state_d = HZ_MEMW;
      default: state_d = HZ_RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (pc_keep && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush_evt && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HZ_RUN;
      fl_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fl_cnt_q    <= fl_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: hand-computed control vectors and
// counter values, plus a narrow-counter, single-cycle-flush instance.
module tb_ex_hazard_ctrl;

  // Control vector: {pc_keep, ifid_keep, ifid_nop, idex_keep, idex_nop, exmem_keep, busy}
  localparam logic [6:0] C_IDLE      = 7'b000_0000;
  localparam logic [6:0] C_IDLE_BUSY = 7'b000_0001;
  localparam logic [6:0] C_FRZ       = 7'b110_1010;
  localparam logic [6:0] C_FRZ_BUSY  = 7'b110_1011;
  localparam logic [6:0] C_FL        = 7'b001_0100;
  localparam logic [6:0] C_FL_BUSY   = 7'b001_0101;
  localparam logic [6:0] C_LU        = 7'b110_0100;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [4:0] id_rs1, id_rs2, ex_wreg;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken, mem_req, mem_ready;

  logic        pc_keep, ifid_keep, ifid_nop, idex_keep, idex_nop, exmem_keep, busy;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_keep2, ifid_keep2, ifid_nop2, idex_keep2, idex_nop2, exmem_keep2, busy2;
  logic [1:0]  stall_cnt2, flush_cnt2;
  logic [6:0]  ctl, ctl2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.FLUSH_LEN(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_keep(pc_keep), .ifid_keep(ifid_keep), .ifid_nop(ifid_nop),
    .idex_keep(idex_keep), .idex_nop(idex_nop), .exmem_keep(exmem_keep),
    .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ex_hazard_ctrl #(.FLUSH_LEN(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_keep(pc_keep2), .ifid_keep(ifid_keep2), .ifid_nop(ifid_nop2),
    .idex_keep(idex_keep2), .idex_nop(idex_nop2), .exmem_keep(exmem_keep2),
    .busy(busy2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  assign ctl  = {pc_keep, ifid_keep, ifid_nop, idex_keep, idex_nop, exmem_keep, busy};
  assign ctl2 = {pc_keep2, ifid_keep2, ifid_nop2, idex_keep2, idex_nop2, exmem_keep2, busy2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_wreg = 5'd0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0;

    // Reset held while a memory wait is pending
    tick();
    check("rst_ctl_1", 32'(ctl), 32'(C_IDLE));
    check("rst_stall_1", 32'(stall_cnt), 32'd0);
    tick();
    check("rst_ctl_2", 32'(ctl), 32'(C_IDLE));
    check("rst_stall_2", 32'(stall_cnt), 32'd0);
    check("rst_flush", 32'(flush_cnt), 32'd0);
    rst = 1'b0; #1;
    check("post_rst_freeze", 32'(ctl), 32'(C_FRZ));
    mem_req = 1'b0; #1;
    check("post_rst_idle", 32'(ctl), 32'(C_IDLE));
    tick();
    check("post_rst_stall", 32'(stall_cnt), 32'd0);

    // Load-use on rs2
    ex_is_load = 1'b1; ex_wreg = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; id_use_rs1 = 1'b1; #1;
    check("lu_rs2", 32'(ctl), 32'(C_LU));
    tick();
    ex_is_load = 1'b0; #1;
    check("lu_cleared", 32'(ctl), 32'(C_IDLE));
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    ex_is_load = 1'b1; ex_wreg = 5'd0; id_rs2 = 5'd0; #1;
    check("lu_x0", 32'(ctl), 32'(C_IDLE));
    ex_wreg = 5'd3; #1;
    check("lu_rs1", 32'(ctl), 32'(C_LU));
    id_use_rs1 = 1'b0; #1;
    check("lu_rs1_unused", 32'(ctl), 32'(C_IDLE));
    ex_is_load = 1'b0; id_use_rs2 = 1'b0;
    tick();
    check("lu_stall_cnt_2", 32'(stall_cnt), 32'd1);

    // Taken branch, FLUSH_LEN=2
    ex_branch_taken = 1'b1; #1;
    check("br_cycle0", 32'(ctl), 32'(C_FL));
    tick();
    ex_branch_taken = 1'b0; #1;
    check("br_cycle1", 32'(ctl), 32'(C_FL_BUSY));
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    tick();
    check("br_done", 32'(ctl), 32'(C_IDLE));

    // Branch beats load-use; branch seen in FLUSH is ignored
    ex_branch_taken = 1'b1; ex_is_load = 1'b1; ex_wreg = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; #1;
    check("br_over_lu", 32'(ctl), 32'(C_FL));
    tick();
    check("br_in_flush", 32'(ctl), 32'(C_FL_BUSY));
    check("br_in_flush_cnt", 32'(flush_cnt), 32'd2);
    ex_branch_taken = 1'b0; ex_is_load = 1'b0; id_use_rs2 = 1'b0;
    tick();
    check("br_over_lu_done", 32'(ctl), 32'(C_IDLE));
    check("br_ignored_cnt", 32'(flush_cnt), 32'd2);

    // Memory freeze for 3 cycles
    mem_req = 1'b1; #1;
    check("mw_c0", 32'(ctl), 32'(C_FRZ));
    tick();
    check("mw_c1", 32'(ctl), 32'(C_FRZ_BUSY));
    tick();
    check("mw_c2", 32'(ctl), 32'(C_FRZ_BUSY));
    tick();
    mem_ready = 1'b1; #1;
    check("mw_ready", 32'(ctl), 32'(C_IDLE_BUSY));
    check("mw_stall_cnt", 32'(stall_cnt), 32'd4);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0; #1;
    check("mw_done", 32'(ctl), 32'(C_IDLE));
    check("mw_stall_cnt_2", 32'(stall_cnt), 32'd4);
    mem_req = 1'b1; mem_ready = 1'b1; #1;
    check("mw_req_ready_run", 32'(ctl), 32'(C_IDLE));
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    check("mw_req_ready_cnt", 32'(stall_cnt), 32'd4);

    // Branch during memory wait: freeze first, flush after
    ex_branch_taken = 1'b1; mem_req = 1'b1; #1;
    check("brmw_frz0", 32'(ctl), 32'(C_FRZ));
    tick();
    check("brmw_frz1", 32'(ctl), 32'(C_FRZ_BUSY));
    tick();
    mem_ready = 1'b1; #1;
    check("brmw_fl0", 32'(ctl), 32'(C_FL_BUSY));
    tick();
    mem_req = 1'b0; mem_ready = 1'b0; ex_branch_taken = 1'b0; #1;
    check("brmw_fl1", 32'(ctl), 32'(C_FL_BUSY));
    check("brmw_flush_cnt", 32'(flush_cnt), 32'd3);
    tick();
    check("brmw_done", 32'(ctl), 32'(C_IDLE));
    check("brmw_stall_cnt", 32'(stall_cnt), 32'd6);

    // Memory wait arriving mid-flush holds the remaining flush cycle
    ex_branch_taken = 1'b1; #1;
    check("flmw_br", 32'(ctl), 32'(C_FL));
    tick();
    ex_branch_taken = 1'b0; mem_req = 1'b1; #1;
    check("flmw_frz0", 32'(ctl), 32'(C_FRZ_BUSY));
    tick();
    check("flmw_frz1", 32'(ctl), 32'(C_FRZ_BUSY));
    tick();
    mem_ready = 1'b1; #1;
    check("flmw_resume", 32'(ctl), 32'(C_FL_BUSY));
    tick();
    mem_req = 1'b0; mem_ready = 1'b0; #1;
    check("flmw_done", 32'(ctl), 32'(C_IDLE));
    check("flmw_flush_cnt", 32'(flush_cnt), 32'd4);
    check("flmw_stall_cnt", 32'(stall_cnt), 32'd8);

    // Saturation on the 2-bit, FLUSH_LEN=1 instance
    rst2 = 1'b0; mem_req = 1'b1; #1;
    check("sat_frz", 32'(ctl2), 32'(C_FRZ));
    tick(); tick(); tick();
    check("sat_stall_3", 32'(stall_cnt2), 32'd3);
    tick(); tick();
    check("sat_stall_hold", 32'(stall_cnt2), 32'd3);
    mem_ready = 1'b1;
    tick();
    mem_req = 1'b0; mem_ready = 1'b0; ex_branch_taken = 1'b1; #1;
    check("fl1_ctl", 32'(ctl2), 32'(C_FL));
    tick(); tick();
    check("fl1_flush_2", 32'(flush_cnt2), 32'd2);
    check("fl1_no_busy", 32'(ctl2), 32'(C_FL));
    tick(); tick();
    check("fl1_flush_sat", 32'(flush_cnt2), 32'd3);
    ex_branch_taken = 1'b0;
    tick();

    // Reset in the middle of a memory wait
    mem_req = 1'b1;
    tick();
    check("midrst_busy", 32'(ctl), 32'(C_FRZ_BUSY));
    rst = 1'b1; #1;
    check("midrst_forced", 32'(ctl), 32'(C_IDLE));
    tick();
    rst = 1'b0; mem_req = 1'b0; #1;
    check("midrst_run", 32'(ctl), 32'(C_IDLE));
    check("midrst_cnt", 32'(stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
